// File: rtl/dram_arb_mc_if.sv
`default_nettype none
// ============================================================================
// Module  : dram_arb_mc_if
// Brief   : Request / MIG app / read-response bundle for dram_arb_mc.
// Rev     : 1.0  initial release
// ============================================================================
interface dram_arb_mc_if #(
  parameter int NCH = 2,
  parameter int CHW = 1,
  parameter int AW  = 28,
  parameter int DW  = 128,
  parameter int IDW = 4
);
  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_ready;
  logic [NCH-1:0]        req_wr;
  logic [NCH*AW-1:0]     req_addr;
  logic [NCH*IDW-1:0]    req_id;
  logic [NCH*DW-1:0]     req_wdata;
  logic [NCH*DW/8-1:0]   req_wmask;
  logic [AW-1:0]         app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [DW-1:0]         app_wdf_data;
  logic [DW/8-1:0]       app_wdf_mask;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;
  logic [DW-1:0]         app_rd_data;
  logic                  app_rd_data_valid;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [CHW-1:0]        rsp_ch;
  logic [IDW-1:0]        rsp_id;
  logic [DW-1:0]         rsp_data;
  logic                  rd_err;

  // master = controller side, slave = clients plus MIG
  modport master (
    input  req_valid, req_wr, req_addr, req_id, req_wdata, req_wmask,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, rsp_ready,
    output req_ready, app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end, rsp_valid, rsp_ch, rsp_id, rsp_data, rd_err
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_id, req_wdata, req_wmask,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, rsp_ready,
    input  req_ready, app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end, rsp_valid, rsp_ch, rsp_id, rsp_data, rd_err
  );
endinterface
`default_nettype wire

// File: rtl/dram_arb_mc.sv
`default_nettype none
// ============================================================================
// Module  : dram_arb_mc
// Brief   : Round-robin NCH-channel arbiter onto a MIG app port with a tag
//           FIFO and credit-limited read-return buffer.
//           Optional counters stat_rd/stat_wr: define DRAM_ARB_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
module dram_arb_mc #(
  parameter int NCH  = 2,
  parameter int CHW  = 1,
  parameter int AW   = 28,
  parameter int DW   = 128,
  parameter int IDW  = 4,
  parameter int ODAW = 3
) (
  input  logic          clk,
  input  logic          rst,
  dram_arb_mc_if.master bus
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_rd,
  output logic [31:0]   stat_wr
`endif
);
  localparam int ODEPTH = 2**ODAW;
  localparam int CW     = ODAW + 1;
  localparam int MW     = DW / 8;
  localparam int TW     = CHW + IDW;
  localparam int RW     = TW + DW;
  localparam logic [CW-1:0]  CRED_MAX = CW'(ODEPTH);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NCH - 1);
  localparam logic [2:0]     CMD_WR   = 3'b000;
  localparam logic [2:0]     CMD_RD   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t          r_state;
  logic [CHW-1:0]  r_ptr;
  logic [CW-1:0]   r_cred;
  logic            r_app_en, r_wren, r_rd_err;
  logic [AW-1:0]   r_addr;
  logic [2:0]      r_cmd;
  logic [IDW-1:0]  r_id;
  logic [CHW-1:0]  r_ch;
  logic [DW-1:0]   r_wdata;
  logic [MW-1:0]   r_wmask;
  logic [TW-1:0]   r_tag_mem [ODEPTH];
  logic [CW-1:0]   r_tag_wp, r_tag_rp;
  logic [RW-1:0]   r_ret_mem [ODEPTH];
  logic [CW-1:0]   r_ret_wp, r_ret_rp;

  logic [CHW-1:0]  w_win;
  logic            w_found;
  int              w_idx;
  logic            w_cred_ok, w_accept, w_acc_wr, w_acc_rd;
  logic            w_tag_empty, w_tag_push, w_ret_empty, w_ret_push, w_rsp_pop;
  logic            w_cmd_done, w_dat_done;

  assign w_cred_ok = (r_cred < CRED_MAX);

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = (int'(r_ptr) + k) % NCH;
      if (!w_found && bus.req_valid[w_idx] && (bus.req_wr[w_idx] || w_cred_ok)) begin
        w_found = 1'b1;
        w_win   = CHW'(w_idx);
      end
    end
  end

  assign w_accept = !rst && (r_state == ST_IDLE) && w_found;
  assign w_acc_wr = bus.req_wr[w_win];
  assign w_acc_rd = w_accept && !w_acc_wr;

  always_comb begin
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_win] = 1'b1;
  end

  assign w_tag_empty = (r_tag_wp == r_tag_rp);
  assign w_tag_push  = (r_state == ST_RD) && bus.app_rdy;
  assign w_ret_push  = bus.app_rd_data_valid && !w_tag_empty;
  assign w_ret_empty = (r_ret_wp == r_ret_rp);
  assign w_rsp_pop   = !w_ret_empty && bus.rsp_ready;
  // Each write strobe counts as done once dropped or accepted this cycle
  assign w_cmd_done  = !r_app_en || bus.app_rdy;
  assign w_dat_done  = !r_wren || bus.app_wdf_rdy;

  always_ff @(posedge clk) begin
    if (w_tag_push) r_tag_mem[r_tag_wp[ODAW-1:0]] <= {r_ch, r_id};
    if (w_ret_push) r_ret_mem[r_ret_wp[ODAW-1:0]] <= {r_tag_mem[r_tag_rp[ODAW-1:0]], bus.app_rd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_cred   <= '0;
      r_app_en <= 1'b0;
      r_wren   <= 1'b0;
      r_rd_err <= 1'b0;
      r_addr   <= '0;
      r_cmd    <= CMD_WR;
      r_id     <= '0;
      r_ch     <= '0;
      r_wdata  <= '0;
      r_wmask  <= '0;
      r_tag_wp <= '0;
      r_tag_rp <= '0;
      r_ret_wp <= '0;
      r_ret_rp <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr   <= bus.req_addr[int'(w_win)*AW +: AW];
            r_id     <= bus.req_id[int'(w_win)*IDW +: IDW];
            r_wdata  <= bus.req_wdata[int'(w_win)*DW +: DW];
            r_wmask  <= bus.req_wmask[int'(w_win)*MW +: MW];
            r_ch     <= w_win;
            r_ptr    <= (w_win == LAST_CH) ? '0 : w_win + 1'b1;
            r_app_en <= 1'b1;
            r_wren   <= w_acc_wr;
            r_cmd    <= w_acc_wr ? CMD_WR : CMD_RD;
            r_state  <= w_acc_wr ? ST_WR : ST_RD;
          end
        end
        ST_RD: begin
          if (bus.app_rdy) begin
            r_app_en <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (bus.app_rdy) r_app_en <= 1'b0;
          if (bus.app_wdf_rdy) r_wren <= 1'b0;
          if (w_cmd_done && w_dat_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      case ({w_acc_rd, w_rsp_pop})
        2'b10:   r_cred <= r_cred + 1'b1;
        2'b01:   r_cred <= r_cred - 1'b1;
        default: r_cred <= r_cred;
      endcase

      if (w_tag_push) r_tag_wp <= r_tag_wp + 1'b1;
      if (w_ret_push) begin
        r_tag_rp <= r_tag_rp + 1'b1;
        r_ret_wp <= r_ret_wp + 1'b1;
      end
      if (w_rsp_pop) r_ret_rp <= r_ret_rp + 1'b1;
      // Stray return data is dropped; only the sticky flag records it
      if (bus.app_rd_data_valid && w_tag_empty) r_rd_err <= 1'b1;
    end
  end

`ifdef DRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd <= '0;
      stat_wr <= '0;
    end else begin
      if (w_tag_push && (stat_rd != 32'hFFFF_FFFF)) stat_rd <= stat_rd + 1'b1;
      if ((r_state == ST_WR) && w_cmd_done && w_dat_done && (stat_wr != 32'hFFFF_FFFF))
        stat_wr <= stat_wr + 1'b1;
    end
  end
`endif

  assign bus.app_addr     = r_addr;
  assign bus.app_cmd      = r_cmd;
  assign bus.app_en       = r_app_en;
  assign bus.app_wdf_data = r_wdata;
  assign bus.app_wdf_mask = r_wmask;
  assign bus.app_wdf_wren = r_wren;
  assign bus.app_wdf_end  = r_wren;
  assign bus.rsp_valid    = !w_ret_empty;
  assign bus.rd_err       = r_rd_err;
  assign {bus.rsp_ch, bus.rsp_id, bus.rsp_data} = r_ret_mem[r_ret_rp[ODAW-1:0]];
endmodule
`default_nettype wire

// File: tb/tb_dram_arb_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_dram_arb_mc
// Brief   : Self-checking bench for dram_arb_mc: directed scenarios plus
//           randomized traffic against a queue-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dram_arb_mc;
  localparam int NCH  = 2;
  localparam int CHW  = 1;
  localparam int AW   = 28;
  localparam int DW   = 128;
  localparam int IDW  = 4;
  localparam int ODAW = 3;
  localparam int ODEPTH = 2**ODAW;
  localparam int MW   = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  dram_arb_mc_if #(.NCH(NCH), .CHW(CHW), .AW(AW), .DW(DW), .IDW(IDW)) bus ();

`ifdef DRAM_ARB_STATS_EN
  logic [31:0] stat_rd, stat_wr;
`endif

  dram_arb_mc #(.NCH(NCH), .CHW(CHW), .AW(AW), .DW(DW), .IDW(IDW), .ODAW(ODAW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef DRAM_ARB_STATS_EN
    ,
    .stat_rd (stat_rd),
    .stat_wr (stat_wr)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_valid = '0;
    bus.req_wr = '0;
    bus.req_addr = '0;
    bus.req_id = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.app_rdy = 1'b0;
    bus.app_wdf_rdy = 1'b0;
    bus.app_rd_data = '0;
    bus.app_rd_data_valid = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [AW-1:0] addr,
                         input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus.req_valid[ch] = 1'b1;
    bus.req_wr[ch] = wr;
    bus.req_addr[ch*AW +: AW] = addr;
    bus.req_id[ch*IDW +: IDW] = id;
    bus.req_wdata[ch*DW +: DW] = d;
    bus.req_wmask[ch*MW +: MW] = m;
  endtask

  task automatic apply_reset();
    cyc();
    drive_idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    bus.req_valid = '1;
    cyc();
    cyc();
    @(negedge clk);
    n_vec++;
    if ({bus.req_ready, bus.app_en, bus.app_wdf_wren, bus.rsp_valid, bus.rd_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ready=%b en=%b wren=%b rv=%b err=%b, want all 0",
               bus.req_ready, bus.app_en, bus.app_wdf_wren, bus.rsp_valid, bus.rd_err);
    end
    cyc();
    drive_idle();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] a5 = {16{8'hA5}};
    apply_reset();
    set_req(0, 1'b0, 28'h100, 4'd3, '0, '0);
    bus.app_rdy = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL rd1_ready: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    n_vec++;
    if ({bus.app_en, bus.app_cmd, bus.app_addr} !== {1'b1, 3'b001, 28'h100}) begin
      n_err++; $display("FAIL rd1_issue: got en=%b cmd=%b addr=%h want 1 001 100", bus.app_en, bus.app_cmd, bus.app_addr);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (bus.app_en !== 1'b0) begin n_err++; $display("FAIL rd1_en_drop: got %b want 0", bus.app_en); end
    cyc();
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data = a5;
    @(negedge clk);
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd1_rsp_early: got %b want 0", bus.rsp_valid); end
    cyc();
    bus.app_rd_data_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_ch, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, 4'd3, a5}) begin
      n_err++; $display("FAIL rd1_rsp: got v=%b ch=%h id=%h d=%h want 1 0 3 %h",
                        bus.rsp_valid, bus.rsp_ch, bus.rsp_id, bus.rsp_data, a5);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd1_rsp_pop: got %b want 0", bus.rsp_valid); end
`ifdef DRAM_ARB_STATS_EN
    n_vec++;
    if (stat_rd !== 32'd1) begin n_err++; $display("FAIL stat_rd: got %0d want 1", stat_rd); end
`endif
  endtask

  task automatic test_write_skew();
    logic [DW-1:0] d = rand_data();
    apply_reset();
    set_req(1, 1'b1, 28'h40, 4'd5, d, 16'h00FF);
    bus.app_wdf_rdy = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL wr_ready: got %b want 10", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    n_vec++;
    if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.app_cmd, bus.app_addr, bus.app_wdf_mask, bus.app_wdf_data}
        !== {3'b111, 3'b000, 28'h40, 16'h00FF, d}) begin
      n_err++; $display("FAIL wr_issue: got en=%b wren=%b end=%b cmd=%b addr=%h mask=%h data=%h",
                        bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.app_cmd, bus.app_addr,
                        bus.app_wdf_mask, bus.app_wdf_data);
    end
    for (int k = 2; k <= 4; k++) begin
      cyc();
      if (k == 4) begin
        bus.app_rdy = 1'b1;
        set_req(0, 1'b1, 28'h44, 4'd1, d, '0);
      end
      @(negedge clk);
      n_vec++;
      if ({bus.app_en, bus.app_wdf_wren, bus.req_ready} !== {1'b1, 1'b0, 2'b00}) begin
        n_err++; $display("FAIL wr_hold_T%0d: got en=%b wren=%b ready=%b want 1 0 00",
                          k, bus.app_en, bus.app_wdf_wren, bus.req_ready);
      end
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if ({bus.app_en, bus.req_ready} !== {1'b0, 2'b01}) begin
      n_err++; $display("FAIL wr_done: got en=%b ready=%b want 0 01", bus.app_en, bus.req_ready);
    end
    cyc();
    bus.req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] rd[8];
    int grants = 0;
    int exp_ch;
    apply_reset();
    set_req(0, 1'b0, 28'h1000, 4'd1, '0, '0);
    set_req(1, 1'b0, 28'h2000, 4'd2, '0, '0);
    bus.app_rdy = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && grants < 8; c++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        n_vec++;
        if (bus.req_ready !== (2'b01 << (grants % 2))) begin
          n_err++; $display("FAIL rr_grant%0d: got %b want ch%0d", grants, bus.req_ready, grants % 2);
        end
        grants++;
      end
      cyc();
    end
    bus.req_valid = '0;
    n_vec++;
    if (grants != 8) begin n_err++; $display("FAIL rr_grant_count: got %0d want 8", grants); end
    repeat (3) cyc();
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        rd[k] = rand_data();
        bus.app_rd_data_valid = 1'b1;
        bus.app_rd_data = rd[k];
      end else begin
        bus.app_rd_data_valid = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        exp_ch = (k - 1) % 2;
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_ch, bus.rsp_id, bus.rsp_data} !==
            {1'b1, exp_ch[0], (exp_ch == 0) ? 4'd1 : 4'd2, rd[k-1]}) begin
          n_err++; $display("FAIL rr_rsp%0d: got v=%b ch=%h id=%h d=%h want ch%0d d=%h",
                            k - 1, bus.rsp_valid, bus.rsp_ch, bus.rsp_id, bus.rsp_data, exp_ch, rd[k-1]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_credit_stall();
    int grants = 0;
    apply_reset();
    set_req(0, 1'b0, 28'h300, 4'd7, '0, '0);
    bus.app_rdy = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.req_ready[0]) grants++;
      if (c < 29) cyc();
    end
    n_vec++;
    if ({grants, bus.req_ready} !== {32'd8, 2'b00}) begin
      n_err++; $display("FAIL credit_limit: got grants=%0d ready=%b want 8 00", grants, bus.req_ready);
    end
    cyc();
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data = rand_data();
    cyc();
    bus.app_rd_data_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.rsp_valid, bus.req_ready} !== {1'b1, 2'b00}) begin
      n_err++; $display("FAIL credit_rsp_held: got rv=%b ready=%b want 1 00", bus.rsp_valid, bus.req_ready);
    end
    cyc();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL credit_pop_cycle: got %b want 00", bus.req_ready); end
    cyc();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL credit_9th: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = '0;
  endtask

  task automatic test_error();
    apply_reset();
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data = rand_data();
    @(negedge clk);
    n_vec++;
    if (bus.rd_err !== 1'b0) begin n_err++; $display("FAIL err_pre: got %b want 0", bus.rd_err); end
    cyc();
    bus.app_rd_data_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.rd_err, bus.rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL err_set: got err=%b rv=%b want 1 0", bus.rd_err, bus.rsp_valid);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (bus.rd_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", bus.rd_err); end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.rd_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", bus.rd_err); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d = rand_data();
    apply_reset();
    set_req(0, 1'b1, 28'h80, 4'd2, rand_data(), '0);
    @(negedge clk);
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    n_vec++;
    if ({bus.app_en, bus.app_wdf_wren} !== 2'b11) begin
      n_err++; $display("FAIL mr_wr_active: got en=%b wren=%b want 11", bus.app_en, bus.app_wdf_wren);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.app_en, bus.app_wdf_wren, bus.rsp_valid} !== 3'b000) begin
      n_err++; $display("FAIL mr_abort: got en=%b wren=%b rv=%b want 000", bus.app_en, bus.app_wdf_wren, bus.rsp_valid);
    end
    cyc();
    set_req(0, 1'b0, 28'h9AB, 4'd9, '0, '0);
    bus.app_rdy = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    n_vec++;
    if ({bus.app_en, bus.app_cmd, bus.app_addr} !== {1'b1, 3'b001, 28'h9AB}) begin
      n_err++; $display("FAIL mr_read_issue: got en=%b cmd=%b addr=%h", bus.app_en, bus.app_cmd, bus.app_addr);
    end
    cyc();
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data = d;
    cyc();
    bus.app_rd_data_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_ch, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, 4'd9, d}) begin
      n_err++; $display("FAIL mr_read_rsp: got v=%b ch=%h id=%h d=%h", bus.rsp_valid, bus.rsp_ch, bus.rsp_id, bus.rsp_data);
    end
  endtask

  task automatic test_random();
    bit               has_req[NCH];
    bit               rq_wr[NCH];
    logic [AW-1:0]    rq_addr[NCH];
    logic [IDW-1:0]   rq_id[NCH];
    logic [DW-1:0]    rq_data[NCH];
    logic [MW-1:0]    rq_mask[NCH];
    logic [CHW+IDW-1:0]    tags[$];
    logic [DW-1:0]         mig_q[$];
    logic [CHW+IDW+DW-1:0] exp_rsp[$];
    logic [NCH-1:0]   exp_ready;
    logic [AW-1:0]    e_addr = '0;
    logic [DW-1:0]    e_data = '0;
    logic [MW-1:0]    e_mask = '0;
    bit pend_c = 0, pend_d = 0, e_rd = 0, ret_now;
    int ptr = 0, cred = 0, win, idx;
    apply_reset();
    for (int ch = 0; ch < NCH; ch++) has_req[ch] = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int ch = 0; ch < NCH; ch++) begin
        if (!has_req[ch] && $urandom_range(0, 2) == 0) begin
          has_req[ch] = 1;
          rq_wr[ch]   = 1'($urandom_range(0, 1));
          rq_addr[ch] = AW'($urandom);
          rq_id[ch]   = IDW'($urandom);
          rq_data[ch] = rand_data();
          rq_mask[ch] = MW'($urandom);
        end
        bus.req_valid[ch] = has_req[ch];
        bus.req_wr[ch] = rq_wr[ch];
        bus.req_addr[ch*AW +: AW] = rq_addr[ch];
        bus.req_id[ch*IDW +: IDW] = rq_id[ch];
        bus.req_wdata[ch*DW +: DW] = rq_data[ch];
        bus.req_wmask[ch*MW +: MW] = rq_mask[ch];
      end
      bus.app_rdy = ($urandom_range(0, 3) != 0);
      bus.app_wdf_rdy = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
      ret_now = (mig_q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.app_rd_data_valid = ret_now;
      bus.app_rd_data = ret_now ? mig_q[0] : '0;
      @(negedge clk);
      // Expected grant: first valid, eligible channel at or after the pointer
      win = -1;
      if (!pend_c && !pend_d) begin
        for (int k = 0; k < NCH; k++) begin
          idx = (ptr + k) % NCH;
          if (win < 0 && has_req[idx] && (rq_wr[idx] || cred < ODEPTH)) win = idx;
        end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      n_vec++;
      if (bus.req_ready !== exp_ready) begin
        n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.req_ready, exp_ready);
      end
      n_vec++;
      if ({bus.app_en, bus.app_wdf_wren} !== {pend_c, pend_d}) begin
        n_err++; $display("FAIL rnd_strobes c%0d: got en=%b wren=%b want %b %b", c, bus.app_en, bus.app_wdf_wren, pend_c, pend_d);
      end
      if (pend_c) begin
        n_vec++;
        if ({bus.app_cmd, bus.app_addr} !== {e_rd ? 3'b001 : 3'b000, e_addr}) begin
          n_err++; $display("FAIL rnd_cmd c%0d: got cmd=%b addr=%h want rd=%b addr=%h", c, bus.app_cmd, bus.app_addr, e_rd, e_addr);
        end
      end
      if (pend_d) begin
        n_vec++;
        if ({bus.app_wdf_data, bus.app_wdf_mask} !== {e_data, e_mask}) begin
          n_err++; $display("FAIL rnd_wdata c%0d: got d=%h m=%h want d=%h m=%h", c, bus.app_wdf_data, bus.app_wdf_mask, e_data, e_mask);
        end
      end
      n_vec++;
      if (bus.rsp_valid !== (exp_rsp.size() > 0)) begin
        n_err++; $display("FAIL rnd_rsp_valid c%0d: got %b want %0d", c, bus.rsp_valid, exp_rsp.size() > 0);
      end
      if (exp_rsp.size() > 0) begin
        n_vec++;
        if ({bus.rsp_ch, bus.rsp_id, bus.rsp_data} !== exp_rsp[0]) begin
          n_err++; $display("FAIL rnd_rsp c%0d: got ch=%h id=%h d=%h want %h", c, bus.rsp_ch, bus.rsp_id, bus.rsp_data, exp_rsp[0]);
        end
        if (bus.rsp_ready) begin
          void'(exp_rsp.pop_front());
          cred--;
        end
      end
      if (pend_c && bus.app_rdy) begin
        pend_c = 0;
        if (e_rd) mig_q.push_back(rand_data());
      end
      if (pend_d && bus.app_wdf_rdy) pend_d = 0;
      if (win >= 0) begin
        e_rd = !rq_wr[win];
        e_addr = rq_addr[win];
        e_data = rq_data[win];
        e_mask = rq_mask[win];
        pend_c = 1;
        pend_d = rq_wr[win];
        ptr = (win + 1) % NCH;
        has_req[win] = 0;
        if (e_rd) begin
          cred++;
          tags.push_back({CHW'(win), rq_id[win]});
        end
      end
      if (ret_now) exp_rsp.push_back({tags.pop_front(), mig_q.pop_front()});
    end
    cyc();
    drive_idle();
    @(negedge clk);
    n_vec++;
    if (bus.rd_err !== 1'b0) begin n_err++; $display("FAIL rnd_no_err: got %b want 0", bus.rd_err); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_read();
    test_write_skew();
    test_round_robin();
    test_credit_stall();
    test_error();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
